// File: rtl/wb_stage.sv
// Registered write-back stage: selects RF write data (ALU / load / NPC), extracts sub-word loads
// and stalls upstream while a load response is outstanding. Optional counter: WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int N  = 32,
  parameter int RA = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic [1:0]             mem2reg,
  input  logic                   regWrite,
  input  logic [N-1:0]           ALUres,
  input  logic [N-1:0]           NPCin,
  input  logic [RA-1:0]          regDest_in,
  input  logic [2:0]             ld_funct3,
  input  logic [$clog2(N/8)-1:0] ld_off,
  input  logic                   mem_rvalid,
  input  logic [N-1:0]           MEMread,
  output logic [N-1:0]           data_out,
  output logic [RA-1:0]          regDest_out,
  output logic                   wr_en,
  output logic                   wb_err,
  output logic [63:0]            retired_cnt
);

  localparam int BO = $clog2(N/8);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_NPC  = 2'b10;
  localparam logic [1:0] SRC_ILL  = 2'b11;

  // Handshake: an instruction transfers on a rising edge where in_valid & in_ready & ~flush.
  // in_ready is low only while a load response is outstanding.

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          accept;
  logic          go_write;

  logic [1:0]    l_m2r;
  logic          l_rw;
  logic [N-1:0]  l_alu;
  logic [N-1:0]  l_npc;
  logic [RA-1:0] l_rd;
  logic [2:0]    l_f3;
  logic [BO-1:0] l_off;

  logic          sel_latched;
  logic [1:0]    c_m2r;
  logic          c_rw;
  logic [N-1:0]  c_alu;
  logic [N-1:0]  c_npc;
  logic [RA-1:0] c_rd;
  logic [2:0]    c_f3;
  logic [BO-1:0] c_off;

  logic [N-1:0]  shifted;
  logic          sign_ld;
  logic [N-1:0]  ext_b;
  logic [N-1:0]  ext_h;
  logic [N-1:0]  ext_w;
  logic [N-1:0]  load_val;
  logic          misalign;
  logic          illegal_f3;
  logic          width_err;
  logic          c_err;
  logic [N-1:0]  wdata;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    next_state = state;
    go_write   = 1'b0;
    case (state)
      WAIT_MEM: begin
        // A flush drops the pending load even if its response arrives the same cycle.
        if (flush) begin
          next_state = IDLE;
        end else if (mem_rvalid) begin
          next_state = WRITE;
          go_write   = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if ((mem2reg == SRC_LOAD) && !mem_rvalid) begin
            next_state = WAIT_MEM;
          end else begin
            next_state = WRITE;
            go_write   = 1'b1;
          end
        end else begin
          next_state = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_m2r <= '0;
      l_rw  <= 1'b0;
      l_alu <= '0;
      l_npc <= '0;
      l_rd  <= '0;
      l_f3  <= '0;
      l_off <= '0;
    end else if (accept) begin
      l_m2r <= mem2reg;
      l_rw  <= regWrite;
      l_alu <= ALUres;
      l_npc <= NPCin;
      l_rd  <= regDest_in;
      l_f3  <= ld_funct3;
      l_off <= ld_off;
    end
  end

  // Completing a waited load uses the latched instruction; every other write comes straight
  // from the instruction being accepted this cycle.
  assign sel_latched = (state == WAIT_MEM);
  assign c_m2r = sel_latched ? l_m2r : mem2reg;
  assign c_rw  = sel_latched ? l_rw  : regWrite;
  assign c_alu = sel_latched ? l_alu : ALUres;
  assign c_npc = sel_latched ? l_npc : NPCin;
  assign c_rd  = sel_latched ? l_rd  : regDest_in;
  assign c_f3  = sel_latched ? l_f3  : ld_funct3;
  assign c_off = sel_latched ? l_off : ld_off;

  always_comb begin
    shifted = MEMread >> {c_off, 3'b000};
    sign_ld = ~c_f3[2];

    ext_b       = {N{sign_ld & shifted[7]}};
    ext_b[7:0]  = shifted[7:0];
    ext_h       = {N{sign_ld & shifted[15]}};
    ext_h[15:0] = shifted[15:0];
    ext_w       = {N{sign_ld & shifted[31]}};
    ext_w[31:0] = shifted[31:0];

    load_val   = shifted;
    misalign   = 1'b0;
    illegal_f3 = 1'b0;
    case (c_f3)
      3'b000, 3'b100: begin
        load_val = ext_b;
      end
      3'b001, 3'b101: begin
        load_val = ext_h;
        misalign = c_off[0];
      end
      3'b010, 3'b110: begin
        load_val = ext_w;
        misalign = |c_off[1:0];
      end
      3'b011: begin
        load_val = shifted;
        misalign = |c_off;
      end
      default: begin
        illegal_f3 = 1'b1;
      end
    endcase

    // Doubleword and unsigned-word loads only exist on the 64-bit datapath.
    width_err = (N == 32) && ((c_f3 == 3'b011) || (c_f3 == 3'b110));

    c_err = (c_m2r == SRC_ILL) ||
            ((c_m2r == SRC_LOAD) && (illegal_f3 || misalign || width_err));

    case (c_m2r)
      SRC_ALU:  wdata = c_alu;
      SRC_LOAD: wdata = load_val;
      SRC_NPC:  wdata = c_npc;
      default:  wdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_out    <= '0;
      regDest_out <= '0;
      wr_en       <= 1'b0;
      wb_err      <= 1'b0;
    end else begin
      state  <= next_state;
      wr_en  <= go_write & c_rw & (c_rd != '0) & ~c_err;
      wb_err <= go_write & c_err;
      if (go_write) begin
        regDest_out <= c_rd;
        if (!c_err) begin
          data_out <= wdata;
        end
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt;

  // Counts every error-free write cycle, including suppressed x0 and regWrite=0 writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == WRITE) && !wb_err) begin
      cnt <= cnt + 64'd1;
    end
  end

  assign retired_cnt = cnt;
`else
  assign retired_cnt = '0;
`endif

endmodule
